branch_predict_resolve: RTL and testbench
=========================================

// Module: branch_predict_resolve
// PURPOSE
//  Parametrised branch resolution + prediction unit for the pipelined MIPS core.
//  Resolves BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ in EX from full register operands.
//  Keeps a direct-mapped table of 2-bit saturating counters that IF reads for a
//  taken prediction. Raises a registered mispredict pulse so the hazard unit can flush IF/ID.
// PARAMETERS
//  XLEN       32     operand / PC width
//  BHT_DEPTH  64     counter entries; power of 2, >=2; IDX_W = log2(BHT_DEPTH)
//  CTR_INIT   2'b01  counter value after reset (weakly not-taken)
//  PERF_W     16     mispredict performance counter width
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       async active-low reset
//  if_pc          in   XLEN    fetch PC for lookup
//  if_pred_taken  out  1       comb: bht[if_pc[IDX_W+1:2]][1]
//  ex_valid       in   1       EX slot holds a real instruction
//  ex_pc          in   XLEN    PC of instruction in EX
//  ex_br_op       in   3       0 none,1 BEQ,2 BNE,3 BGTZ,4 BLEZ,5 BLTZ,6 BGEZ,7 reserved
//  ex_rs          in   XLEN    rs operand (forwarded)
//  ex_rt          in   XLEN    rt operand (forwarded; used by BEQ/BNE only)
//  ex_pred_taken  in   1       prediction carried down the pipe for this branch
//  ex_taken       out  1       comb: resolved direction (0 if not a branch)
//  mp_valid       out  1       registered 1-cycle mispredict pulse
//  mp_taken       out  1       registered actual direction for the mispredicted branch
//  mp_count       out  PERF_W  total mispredicts, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): all BHT entries=CTR_INIT; mp_valid=0, mp_taken=0, mp_count=0.
//    Asserting reset mid-operation discards any pending update; no pulse after release.
//  - Index = pc[IDX_W+1:2] for both lookup and update (word-aligned PCs).
//  - Conditions (signed, XLEN-wide): zf=(rs==rt); neg=rs[XLEN-1]; z0=(rs==0).
//    BEQ zf; BNE !zf; BGTZ !neg&!z0; BLEZ neg|z0; BLTZ neg; BGEZ !neg.
//    Ops 0 and 7 are not branches: ex_taken=0, no update, no mispredict.
//  - is_br = ex_valid & op in 1..6. At the clk edge when is_br=1:
//    ctr <= taken ? sat_inc(ctr) : sat_dec(ctr); 3 stays 3, 0 stays 0.
//  - Mispredict: mp_valid <= is_br & (ex_taken != ex_pred_taken); mp_taken <= ex_taken.
//    Latency: 1 cycle after EX. mp_valid is held 0 whenever the condition is false.
//    mp_count += 1 on each mp_valid-setting edge; it holds at 2^PERF_W-1.
//  - Same-index lookup and update in one cycle: if_pred_taken shows the pre-update
//    value (no bypass). The new value is visible the next cycle.
//  - Aliasing PCs share an entry. No tags and no invalidation.
//  - ex_valid=0 blocks updates and mispredicts regardless of ex_br_op.
// TESTING
//  1 Reset, lookup pc=0x40 -> if_pred_taken=0; all 64 entries read CTR_INIT.
//  2 BEQ rs=rt=5, pred=0, pc=0x40 -> ex_taken=1; next cycle mp_valid=1, mp_taken=1,
//    mp_count=1; entry[16]=2 and lookup 0x40 -> 1.
//  3 BGTZ/BLEZ/BLTZ/BGEZ with rs=0, 1, 0x80000000, pred matching result -> taken =
//    0/1/0, 1/0/1, 0/0/1, 1/1/0 respectively; mp_valid=0 throughout.
//  4 Four taken updates then two not-taken at one pc -> ctr 2,3,3,3,2,1;
//    prediction flips to 0 only after the second not-taken.
//  5 Same-cycle lookup + update on one index -> old prediction that cycle, new next;
//    pc 0x40 vs 0x140 (DEPTH=64) alias the same entry.
//  6 ex_valid=0 with op=BEQ mismatch -> no pulse, no update; op=7 -> ex_taken=0;
//    rst_n low mid-stream -> outputs 0 immediately; PERF_W=2 count saturates at 3.

Source files
------------

// File: rtl/branch_predict_resolve.sv
// Branch resolution in EX plus a direct-mapped table of 2-bit counters read by IF.
// Latency: ex_taken/if_pred_taken combinational; mispredict pulse and table update land one cycle after EX.
// Backpressure: none; every valid EX branch is resolved and accounted in the cycle it is presented.
module branch_predict_resolve #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [2:0]        ex_br_op,
    input  logic [XLEN-1:0]   ex_rs,
    input  logic [XLEN-1:0]   ex_rt,
    input  logic              ex_pred_taken,
    output logic              ex_taken,
    output logic              mp_valid,
    output logic              mp_taken,
    output logic [PERF_W-1:0] mp_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_BGTZ = 3'd3;
    localparam logic [2:0] OP_BLEZ = 3'd4;
    localparam logic [2:0] OP_BLTZ = 3'd5;
    localparam logic [2:0] OP_BGEZ = 3'd6;

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             zf;
    logic             neg;
    logic             z0;
    logic             is_br;
    logic             mispredict;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;

    // PCs are word aligned; bits above the index simply alias onto the same entry.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    // Prediction is the counter MSB; no bypass from a same-cycle update.
    assign if_pred_taken = bht[if_idx][1];

    assign zf  = (ex_rs == ex_rt);
    assign neg = ex_rs[XLEN-1];
    assign z0  = (ex_rs == '0);

    // Resolve the branch direction from the forwarded operands.
    always_comb begin
        ex_taken = 1'b0;
        case (ex_br_op)
            OP_BEQ:  ex_taken = zf;
            OP_BNE:  ex_taken = !zf;
            OP_BGTZ: ex_taken = !neg && !z0;
            OP_BLEZ: ex_taken = neg || z0;
            OP_BLTZ: ex_taken = neg;
            OP_BGEZ: ex_taken = !neg;
            default: ex_taken = 1'b0;
        endcase
    end

    assign is_br      = ex_valid && (ex_br_op != 3'd0) && (ex_br_op != 3'd7);
    assign mispredict = is_br && (ex_taken != ex_pred_taken);
    assign ctr_cur    = bht[ex_idx];

    // Saturating counter step toward the resolved direction.
    always_comb begin
        ctr_next = ctr_cur;
        if (ex_taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
        end
    end

    // Counter table: reset to weakly not-taken, trained by every valid branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
        end else if (is_br) begin
            bht[ex_idx] <= ctr_next;
        end
    end

    // Registered mispredict pulse and saturating mispredict counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mp_valid <= 1'b0;
            mp_taken <= 1'b0;
            mp_count <= '0;
        end else begin
            mp_valid <= mispredict;
            mp_taken <= ex_taken;
            if (mispredict && (mp_count != {PERF_W{1'b1}}))
                mp_count <= mp_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Randomised and directed stimulus for branch_predict_resolve against a behavioural model.
// Comb outputs are checked at drive time; mispredict pulses go through a cycle-stamped scoreboard.
// The DUT runs with a 2-bit perf counter so saturation is reached quickly.
module tb_branch_predict_resolve;
    localparam int PW = 2;

    logic          clk;
    logic          rst_n;
    logic [31:0]   if_pc;
    logic          if_pred_taken;
    logic          ex_valid;
    logic [31:0]   ex_pc;
    logic [2:0]    ex_br_op;
    logic [31:0]   ex_rs;
    logic [31:0]   ex_rt;
    logic          ex_pred_taken;
    logic          ex_taken;
    logic          mp_valid;
    logic          mp_taken;
    logic [PW-1:0] mp_count;

    branch_predict_resolve #(.XLEN(32), .BHT_DEPTH(64), .CTR_INIT(2'b01), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_op(ex_br_op), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
        .mp_valid(mp_valid), .mp_taken(mp_taken), .mp_count(mp_count)
    );

    typedef struct {
        int   cyc;
        logic taken;
        int   cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   ctr [64];
    int   cnt      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        case (op)
            3'd1: return rs == rt;
            3'd2: return rs != rt;
            3'd3: return $signed(rs) > 0;
            3'd4: return $signed(rs) <= 0;
            3'd5: return $signed(rs) < 0;
            3'd6: return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ctr[i] = 1;
        cnt = 0;
        q.delete();
    endtask

    // Drive one EX/IF cycle, check comb outputs, advance the model, queue any expected pulse.
    task automatic step(input logic v, input logic [31:0] pc, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt, input logic pred,
                        input logic [31:0] lpc);
        logic t;
        int   i;
        exp_t e;
        @(negedge clk);
        ex_valid = v; ex_pc = pc; ex_br_op = op; ex_rs = rs; ex_rt = rt;
        ex_pred_taken = pred; if_pc = lpc;
        #1;
        t = ref_taken(op, rs, rt);
        chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, ctr[idx(lpc)] >= 2});
        if (v || op == 3'd0 || op == 3'd7) chk("ex_taken", {31'd0, ex_taken}, {31'd0, t});
        if (v && op >= 3'd1 && op <= 3'd6) begin
            i = idx(pc);
            ctr[i] = t ? ((ctr[i] == 3) ? 3 : ctr[i] + 1) : ((ctr[i] == 0) ? 0 : ctr[i] - 1);
            if (t != pred) begin
                cnt     = (cnt == 3) ? 3 : cnt + 1;
                e.cyc   = cyc + 1;
                e.taken = t;
                e.cnt   = cnt;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic [31:0] lpc);
        step(1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, lpc);
    endtask

    // Monitor: every cycle the registered outputs either match the queued pulse or stay quiet.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("mp_valid", {31'd0, mp_valid}, 32'd1);
                chk("mp_taken", {31'd0, mp_taken}, {31'd0, e.taken});
                chk("mp_count", {30'd0, mp_count}, e.cnt);
            end else begin
                chk("mp_valid_idle", {31'd0, mp_valid}, 32'd0);
            end
        end
    end

    logic [31:0] rs_tab [3];
    logic [3:0]  res_tab [3];
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [31:0] r_pc;

    initial begin
        rs_tab[0] = 32'h0; rs_tab[1] = 32'h1; rs_tab[2] = 32'h8000_0000;
        // bit k -> expected direction for op BGTZ+k
        res_tab[0] = 4'b1010; res_tab[1] = 4'b1001; res_tab[2] = 4'b0110;
        model_reset();
        rst_n = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_br_op = '0; ex_rs = '0; ex_rt = '0;
        ex_pred_taken = 1'b0; if_pc = 32'h40;
        #1;
        chk("rst_mp_valid", {31'd0, mp_valid}, 32'd0);
        chk("rst_mp_taken", {31'd0, mp_taken}, 32'd0);
        chk("rst_mp_count", {30'd0, mp_count}, 32'd0);
        chk("rst_pred_0x40", {31'd0, if_pred_taken}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // All entries start weakly not-taken.
        for (int i = 0; i < 64; i++) idle(32'(i * 4));

        // BEQ mispredicted as not-taken at 0x40.
        step(1'b1, 32'h40, 3'd1, 32'd5, 32'd5, 1'b0, 32'h40);
        idle(32'h40);
        chk("beq_trained_pred", {31'd0, if_pred_taken}, 32'd1);

        // Single-operand branches with correct predictions taken from a fixed table.
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++)
                step(1'b1, 32'h80, 3'(3 + k), rs_tab[r], 32'h1234, res_tab[r][k], 32'h80);

        // Saturation walk at 0x100: four taken, two not-taken.
        for (int k = 0; k < 6; k++)
            step(1'b1, 32'h100, 3'd2, 32'd1, (k < 4) ? 32'd2 : 32'd1, k < 4, 32'h100);
        idle(32'h100);

        // Same-cycle lookup/update, then alias 0x140 onto entry 16.
        step(1'b1, 32'h40, 3'd1, 32'd7, 32'd7, 1'b1, 32'h40);
        idle(32'h140);
        step(1'b1, 32'h140, 3'd2, 32'd7, 32'd7, 1'b1, 32'h40);
        step(1'b1, 32'h140, 3'd2, 32'd7, 32'd7, 1'b1, 32'h40);
        step(1'b1, 32'h140, 3'd2, 32'd7, 32'd7, 1'b1, 32'h40);
        idle(32'h40);

        // Invalid slot and reserved op produce nothing.
        step(1'b0, 32'h40, 3'd1, 32'd1, 32'd1, 1'b0, 32'h40);
        step(1'b1, 32'h40, 3'd7, 32'd1, 32'd1, 1'b1, 32'h40);
        idle(32'h40);

        // Reset asserted mid-stream with a pulse out and another mispredict in EX.
        step(1'b1, 32'h200, 3'd1, 32'd3, 32'd3, 1'b0, 32'h200);
        @(negedge clk);
        ex_valid = 1'b1; ex_pc = 32'h200; ex_br_op = 3'd1; ex_rs = 32'd3; ex_rt = 32'd3;
        ex_pred_taken = 1'b0; if_pc = 32'h200;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mp_valid", {31'd0, mp_valid}, 32'd0);
        chk("midrst_mp_count", {30'd0, mp_count}, 32'd0);
        chk("midrst_pred", {31'd0, if_pred_taken}, 32'd0);
        model_reset();
        @(negedge clk);
        ex_valid = 1'b0;
        rst_n = 1'b1;
        idle(32'h200);
        idle(32'h200);

        // Randomised traffic over a small PC window to exercise aliasing and saturation.
        for (int n = 0; n < 3000; n++) begin
            r_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            case ($urandom_range(0, 5))
                0: r_rs = 32'h0;
                1: r_rs = 32'h1;
                2: r_rs = 32'hFFFF_FFFF;
                3: r_rs = 32'h8000_0000;
                4: r_rs = 32'h7FFF_FFFF;
                default: r_rs = $urandom;
            endcase
            r_rt = ($urandom_range(0, 1) == 1) ? r_rs : $urandom;
            step($urandom_range(0, 9) < 8, r_pc, 3'($urandom_range(0, 7)), r_rs, r_rt,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? r_pc : {22'd0, 8'($urandom_range(0, 255)), 2'b00});
        end
        idle(32'h0);
        idle(32'h0);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
